uart_frame_to_mem: RTL and testbench
====================================

Name: uart_frame_to_mem

Overview:
Assembles the UART receiver's byte stream into fixed-length write frames (data field plus address field, byte counts and field order parametrised) and issues one memory write per complete frame over a valid/ready handshake. It sits between the UART RX byte output and the on-chip buffer memory. Frame sync is recovered by an inter-byte timeout, and bytes arriving while a write is stalled are reported as overruns.

Parameters:
DATA_BYTES, 1, bytes in the data field (1..4); mem_wdata width = 8*DATA_BYTES
ADDR_BYTES, 1, bytes in the address field (1..2); mem_addr width = 8*ADDR_BYTES
ADDR_FIRST, 0, 0 = data field sent first, 1 = address field sent first
TIMEOUT_CYCLES, 1000, idle clk cycles between bytes that abort a partial frame; 0 disables the timeout
CNT_W, 16, width of frame_count

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  asynchronous active-low reset
rx_byte  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_byte valid
mem_we  out  1  write request; held until accepted
mem_ready  in  1  memory accepts the write when mem_we && mem_ready
mem_addr  out  8*ADDR_BYTES  write address, stable while mem_we
mem_wdata  out  8*DATA_BYTES  write data, stable while mem_we
busy  out  1  high in COLLECT or WRITE
timeout_err  out  1  one-cycle pulse: partial frame discarded
overrun_err  out  1  one-cycle pulse: byte dropped during WRITE
frame_count  out  CNT_W  completed writes, wraps modulo 2^CNT_W

Behaviour:
- One clock; reset asynchronous, active-low. All state resets on the asserting edge of rst_n. On reset: state=IDLE, byte_cnt=0, timer=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout_err=0, overrun_err=0, frame_count=0. Reset mid-frame or mid-write discards the frame. No write is issued after reset deasserts until a new full frame arrives.
- FRAME_LEN = DATA_BYTES + ADDR_BYTES. The first field is data when ADDR_FIRST=0 and address when ADDR_FIRST=1. Each field is sent MSB first and shifted left into its register.
- IDLE: on rx_valid, store the byte, set byte_cnt=1, clear the timer, go to COLLECT. If FRAME_LEN == 1 is impossible (minimum length is 2).
- COLLECT: on rx_valid, store the byte and increment byte_cnt. If it is the last byte (byte_cnt == FRAME_LEN-1 before the increment), go to WRITE and assert mem_we registered, so mem_we is high the cycle after the last rx_valid (latency 1). Without rx_valid the timer increments. When the timer reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), pulse timeout_err for 1 cycle, clear byte_cnt, go to IDLE.
- WRITE: mem_we=1, with mem_addr and mem_wdata stable. When mem_ready=1, the write completes: next cycle mem_we=0, frame_count+1, state=IDLE.
  - rx_valid in the same cycle as completion: the byte becomes byte 1 of the next frame (state=COLLECT, byte_cnt=1). No loss.
  - rx_valid in WRITE without mem_ready: the byte is dropped, overrun_err pulses 1 cycle, and the state is unchanged.
- mem_addr and mem_wdata update only when entering WRITE; they hold their last values otherwise.
- The timer is CLOG2(TIMEOUT_CYCLES+1) bits, saturating, and cleared on every accepted byte. It does not run in IDLE or WRITE.
- frame_count wraps from 2^CNT_W-1 to 0 with no flag.
- timeout_err and overrun_err are never high at the same time (they occur in disjoint states).

Decomposition:
- Package uart_mem_pkg: state enum {IDLE, COLLECT, WRITE}, UART_BYTE_W=8, and a shared localparam function for the field width.
- One natural sub-module: byte_field_shifter (parametrised N-byte MSB-first shift register with load enable), instanced once for the address field and once for the data field.

Test Plan:
- Defaults; bytes 0xA5 then 0x3C, mem_ready=1 -> mem_we is high for 1 cycle, one cycle after the second strobe, with mem_wdata=0xA5, mem_addr=0x3C; frame_count=1.
- DATA_BYTES=2, ADDR_BYTES=2, ADDR_FIRST=1; bytes 0x12,0x34,0xBE,0xEF -> mem_addr=0x1234, mem_wdata=0xBEEF.
- TIMEOUT_CYCLES=10; send 0x11, wait 10 cycles, then send 0x22,0x33 -> timeout_err pulses once, and the write is data=0x22, addr=0x33.
- mem_ready=0 for 20 cycles after the frame, with one rx_valid (0x55) during the stall -> overrun_err pulses once, mem_we and the outputs are held, and the write completes when ready rises; 0x55 does not appear in any frame.
- rx_valid 0x77 in the same cycle mem_ready completes the write, followed by 0x88 -> the next write is data=0x77, addr=0x88; no overrun.
- Assert rst_n low after 1 byte of a frame, then send a fresh 2-byte frame -> exactly one write from the fresh bytes; frame_count=1.

Source files
------------

// File: rtl/uart_frame_to_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mem_pkg
//  Description : Shared types and constants for the UART frame-to-memory
//                bridge: FSM state encoding, byte width, field-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_mem_pkg;

   localparam int UART_BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2
   } state_t;

   // Bit width of a field made of nbytes UART bytes
   function automatic int field_w(input int nbytes);
      return nbytes * UART_BYTE_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_to_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_to_mem_if
//  Description : Memory write port (valid/ready) between the frame assembler
//                and the buffer memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_frame_to_mem_if
   import uart_mem_pkg::*;
#(
   parameter int DATA_BYTES = 1,
   parameter int ADDR_BYTES = 1
) ();

   logic                            mem_we;
   logic                            mem_ready;
   logic [field_w(ADDR_BYTES)-1:0]  mem_addr;
   logic [field_w(DATA_BYTES)-1:0]  mem_wdata;

   // Frame assembler side: issues the write
   modport master (
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ready
   );

   // Memory side: accepts the write
   modport slave (
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ready
   );

endinterface
`default_nettype wire

// File: rtl/uart_frame_to_mem_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : byte_field_shifter
//  Description : N-byte MSB-first shift register with load enable. Exposes
//                the value the register will hold after the current cycle so
//                the last byte of a frame can be captured in the same edge.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_field_shifter
   import uart_mem_pkg::*;
#(
   parameter int N_BYTES = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          shift_en,
   input  logic [UART_BYTE_W-1:0]        byte_in,
   output logic [field_w(N_BYTES)-1:0]   q_next
);

   localparam int W = field_w(N_BYTES);

   logic [W-1:0] q;

   generate
      if (N_BYTES == 1) begin : g_single
         assign q_next = shift_en ? byte_in : q;
      end else begin : g_multi
         assign q_next = shift_en ? {q[W-UART_BYTE_W-1:0], byte_in} : q;
      end
   endgenerate

   // Field register: new bytes enter at the LSB end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= q_next;
   end

endmodule
`default_nettype wire

// File: rtl/uart_frame_to_mem.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_to_mem
//  Description : Collects UART bytes into fixed-length address/data frames
//                and issues one valid/ready memory write per frame. A partial
//                frame is discarded after an inter-byte timeout; bytes that
//                arrive while a write is stalled are dropped and flagged.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_frame_to_mem
   import uart_mem_pkg::*;
#(
   parameter int DATA_BYTES     = 1,
   parameter int ADDR_BYTES     = 1,
   parameter int ADDR_FIRST     = 0,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [UART_BYTE_W-1:0] rx_byte,
   input  logic                   rx_valid,
   uart_frame_to_mem_if.master    mem,
   output logic                   busy,
   output logic                   timeout_err,
   output logic                   overrun_err,
   output logic [CNT_W-1:0]       frame_count
);

   localparam int FRAME_LEN   = DATA_BYTES + ADDR_BYTES;
   localparam int FIRST_BYTES = (ADDR_FIRST != 0) ? ADDR_BYTES : DATA_BYTES;
   localparam int BCNT_W      = $clog2(FRAME_LEN + 1);
   localparam int TMR_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int AW          = field_w(ADDR_BYTES);
   localparam int DW          = field_w(DATA_BYTES);

   state_t              state, state_next;
   logic [BCNT_W-1:0]   byte_cnt, byte_cnt_next;
   logic [TMR_W-1:0]    timer, timer_next;
   logic                accept, load_out, to_next, ov_next, cnt_inc;
   logic                we_r;
   logic [AW-1:0]       addr_r, addr_nx;
   logic [DW-1:0]       wdata_r, wdata_nx;
   logic [BCNT_W-1:0]   byte_idx;
   logic                in_first, shift_addr, shift_data;

   // Position of the byte being accepted; a byte taken in IDLE or on write
   // completion always starts a new frame.
   assign byte_idx   = (state == COLLECT) ? byte_cnt : '0;
   assign in_first   = (byte_idx < BCNT_W'(FIRST_BYTES));
   assign shift_addr = accept && ((ADDR_FIRST != 0) ? in_first : !in_first);
   assign shift_data = accept && ((ADDR_FIRST != 0) ? !in_first : in_first);

   byte_field_shifter #(.N_BYTES(ADDR_BYTES)) u_addr_field (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_addr),
      .byte_in  (rx_byte),
      .q_next   (addr_nx)
   );

   byte_field_shifter #(.N_BYTES(DATA_BYTES)) u_data_field (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_data),
      .byte_in  (rx_byte),
      .q_next   (wdata_nx)
   );

   // Next-state, byte counting, timeout and error detection
   always_comb begin
      state_next    = state;
      byte_cnt_next = byte_cnt;
      timer_next    = timer;
      accept        = 1'b0;
      load_out      = 1'b0;
      to_next       = 1'b0;
      ov_next       = 1'b0;
      cnt_inc       = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid) begin
               accept        = 1'b1;
               byte_cnt_next = BCNT_W'(1);
               timer_next    = '0;
               state_next    = COLLECT;
            end
         end
         COLLECT: begin
            if (rx_valid) begin
               accept        = 1'b1;
               timer_next    = '0;
               byte_cnt_next = byte_cnt + 1'b1;
               if (byte_cnt == BCNT_W'(FRAME_LEN - 1)) begin
                  load_out   = 1'b1;
                  state_next = WRITE;
               end
            end else if ((TIMEOUT_CYCLES != 0) &&
                         (timer == TMR_W'(TIMEOUT_CYCLES - 1))) begin
               to_next       = 1'b1;
               byte_cnt_next = '0;
               timer_next    = '0;
               state_next    = IDLE;
            end else if (timer != '1) begin
               timer_next = timer + 1'b1;
            end
         end
         WRITE: begin
            if (mem.mem_ready) begin
               cnt_inc       = 1'b1;
               byte_cnt_next = '0;
               state_next    = IDLE;
               // A byte arriving with the completion opens the next frame
               if (rx_valid) begin
                  accept        = 1'b1;
                  byte_cnt_next = BCNT_W'(1);
                  timer_next    = '0;
                  state_next    = COLLECT;
               end
            end else if (rx_valid) begin
               ov_next = 1'b1;
            end
         end
         default: begin
            state_next    = IDLE;
            byte_cnt_next = '0;
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         byte_cnt    <= '0;
         timer       <= '0;
         we_r        <= 1'b0;
         addr_r      <= '0;
         wdata_r     <= '0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_next;
         byte_cnt    <= byte_cnt_next;
         timer       <= timer_next;
         we_r        <= (state_next == WRITE);
         timeout_err <= to_next;
         overrun_err <= ov_next;
         if (load_out) begin
            addr_r  <= addr_nx;
            wdata_r <= wdata_nx;
         end
         if (cnt_inc) frame_count <= frame_count + 1'b1;
      end
   end

   assign mem.mem_we    = we_r;
   assign mem.mem_addr  = addr_r;
   assign mem.mem_wdata = wdata_r;
   assign busy          = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_to_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_to_mem
//  Description : Directed bench for uart_frame_to_mem. Two configurations are
//                instantiated (1+1 bytes data-first, 2+2 bytes address-first);
//                one is active at a time. A frame/queue model predicts the
//                write stream and error pulses and is compared every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_frame_to_mem;
   import uart_mem_pkg::*;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_byte   = 8'h00;
   logic       rx_valid  = 1'b0;
   logic       mem_ready = 1'b1;
   logic       sel       = 1'b0;   // 0: config A, 1: config B

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   int to_count = 0;
   int ov_count = 0;

   // ---------------- DUT A: 1 data + 1 addr, data first, timeout 10 -------
   uart_frame_to_mem_if #(.DATA_BYTES(1), .ADDR_BYTES(1)) bus_a ();
   logic       busy_a, to_a, ov_a;
   logic [3:0] cnt_a;
   assign bus_a.mem_ready = mem_ready;

   uart_frame_to_mem #(
      .DATA_BYTES(1), .ADDR_BYTES(1), .ADDR_FIRST(0),
      .TIMEOUT_CYCLES(10), .CNT_W(4)
   ) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid & ~sel),
      .mem         (bus_a),
      .busy        (busy_a),
      .timeout_err (to_a),
      .overrun_err (ov_a),
      .frame_count (cnt_a)
   );

   // ---------------- DUT B: 2 data + 2 addr, address first ---------------
   uart_frame_to_mem_if #(.DATA_BYTES(2), .ADDR_BYTES(2)) bus_b ();
   logic        busy_b, to_b, ov_b;
   logic [15:0] cnt_b;
   assign bus_b.mem_ready = mem_ready;

   uart_frame_to_mem #(
      .DATA_BYTES(2), .ADDR_BYTES(2), .ADDR_FIRST(1),
      .TIMEOUT_CYCLES(1000), .CNT_W(16)
   ) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid & sel),
      .mem         (bus_b),
      .busy        (busy_b),
      .timeout_err (to_b),
      .overrun_err (ov_b),
      .frame_count (cnt_b)
   );

   // Outputs of whichever configuration is active
   wire        act_we    = sel ? bus_b.mem_we : bus_a.mem_we;
   wire [15:0] act_addr  = sel ? bus_b.mem_addr : {8'h00, bus_a.mem_addr};
   wire [31:0] act_wdata = sel ? {16'h0, bus_b.mem_wdata} : {24'h0, bus_a.mem_wdata};
   wire        act_busy  = sel ? busy_b : busy_a;
   wire        act_to    = sel ? to_b : to_a;
   wire        act_ov    = sel ? ov_b : ov_a;
   wire [15:0] act_cnt   = sel ? cnt_b : {12'h0, cnt_a};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ------------------------------------
   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   logic [7:0] frame[$];     // bytes of the frame being collected
   wr_t        wq[$];        // write expected on the bus (at most one)
   int         idle_cycles = 0;
   logic       exp_to  = 1'b0;
   logic       exp_ov  = 1'b0;
   logic [15:0] exp_cnt = 16'h0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            frame.delete();
            wq.delete();
            idle_cycles = 0;
            exp_to  = 1'b0;
            exp_ov  = 1'b0;
            exp_cnt = 16'h0;
         end else begin
            int   flen, f1, tmo;
            logic [15:0] mask;
            logic hs, done;
            wr_t  w;
            flen = sel ? 4 : 2;
            f1   = sel ? 2 : 1;
            tmo  = sel ? 1000 : 10;
            mask = sel ? 16'hFFFF : 16'h000F;
            hs   = (wq.size() > 0) && mem_ready;
            done = 1'b0;
            w    = '0;
            exp_to = 1'b0;
            exp_ov = 1'b0;
            if (rx_valid) begin
               if (wq.size() > 0 && !mem_ready) begin
                  exp_ov = 1'b1;
               end else begin
                  frame.push_back(rx_byte);
                  idle_cycles = 0;
                  if (frame.size() == flen) begin
                     logic [31:0] first, second;
                     first  = 0;
                     second = 0;
                     for (int i = 0; i < flen; i++) begin
                        if (i < f1) first  = (first  << 8) | 32'(frame[i]);
                        else        second = (second << 8) | 32'(frame[i]);
                     end
                     if (sel) begin w.a = first[15:0];  w.d = second; end
                     else     begin w.a = second[15:0]; w.d = first;  end
                     frame.delete();
                     done = 1'b1;
                  end
               end
            end else if (frame.size() > 0 && tmo != 0) begin
               idle_cycles++;
               if (idle_cycles == tmo) begin
                  frame.delete();
                  idle_cycles = 0;
                  exp_to = 1'b1;
               end
            end
            if (hs) begin
               void'(wq.pop_front());
               exp_cnt = (exp_cnt + 16'h1) & mask;
            end
            if (done) wq.push_back(w);
         end
      end
   end

   // ---------------- per-cycle compare -------------------------------------
   initial begin
      forever begin
         @(negedge clk);
         chk("mem_we", {31'h0, act_we}, {31'h0, (wq.size() > 0)});
         if (wq.size() > 0) begin
            chk("mem_addr", {16'h0, act_addr}, {16'h0, wq[0].a});
            chk("mem_wdata", act_wdata, wq[0].d);
         end
         chk("busy", {31'h0, act_busy}, {31'h0, (frame.size() > 0 || wq.size() > 0)});
         chk("timeout_err", {31'h0, act_to}, {31'h0, exp_to});
         chk("overrun_err", {31'h0, act_ov}, {31'h0, exp_ov});
         chk("frame_count", {16'h0, act_cnt}, {16'h0, exp_cnt});
         if (act_to) to_count++;
         if (act_ov) ov_count++;
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   // All helpers start and end 1 time unit after a rising edge.
   task automatic send(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic s);
      rst_n = 1'b0;
      sel   = s;
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed tests ----------------------------------------
   initial begin
      idle(3);
      do_reset(1'b0);
      @(negedge clk);
      chk("reset_addr", {16'h0, act_addr}, 32'h0);
      chk("reset_wdata", act_wdata, 32'h0);
      chk("reset_cnt", {16'h0, act_cnt}, 32'h0);
      @(posedge clk); #1;

      // Basic frame, data first
      send(8'hA5);
      send(8'h3C);
      @(negedge clk);
      chk("t1_we", {31'h0, act_we}, 32'h1);
      chk("t1_wdata", act_wdata, 32'h0000_00A5);
      chk("t1_addr", {16'h0, act_addr}, 32'h0000_003C);
      @(negedge clk);
      chk("t1_we_drop", {31'h0, act_we}, 32'h0);
      chk("t1_cnt", {16'h0, act_cnt}, 32'h1);
      @(posedge clk); #1;

      // Inter-byte timeout: exactly 10 idle cycles discards the partial frame
      send(8'h11);
      idle(10);
      @(negedge clk);
      chk("t3_timeout_pulse", {31'h0, act_to}, 32'h1);
      @(posedge clk); #1;
      send(8'h22);
      send(8'h33);
      @(negedge clk);
      chk("t3_wdata", act_wdata, 32'h0000_0022);
      chk("t3_addr", {16'h0, act_addr}, 32'h0000_0033);
      @(posedge clk); #1;
      idle(1);

      // 9 idle cycles is still inside the window
      send(8'h44);
      idle(9);
      send(8'h66);
      @(negedge clk);
      chk("t3b_wdata", act_wdata, 32'h0000_0044);
      chk("t3b_addr", {16'h0, act_addr}, 32'h0000_0066);
      @(posedge clk); #1;
      idle(1);

      // Stall with one overrun byte
      mem_ready = 1'b0;
      send(8'hC1);
      send(8'hC2);
      idle(8);
      send(8'h55);
      idle(10);
      @(negedge clk);
      chk("t4_we_held", {31'h0, act_we}, 32'h1);
      chk("t4_wdata_held", act_wdata, 32'h0000_00C1);
      chk("t4_addr_held", {16'h0, act_addr}, 32'h0000_00C2);
      @(posedge clk); #1;
      mem_ready = 1'b1;
      idle(2);
      send(8'hD1);
      send(8'hD2);
      @(negedge clk);
      chk("t4_next_wdata", act_wdata, 32'h0000_00D1);
      chk("t4_next_addr", {16'h0, act_addr}, 32'h0000_00D2);
      @(posedge clk); #1;
      idle(1);

      // Byte arriving in the completion cycle starts the next frame
      mem_ready = 1'b0;
      send(8'hE1);
      send(8'hE2);
      idle(3);
      mem_ready = 1'b1;
      send(8'h77);
      send(8'h88);
      @(negedge clk);
      chk("t5_wdata", act_wdata, 32'h0000_0077);
      chk("t5_addr", {16'h0, act_addr}, 32'h0000_0088);
      chk("t5_overruns", ov_count, 32'd1);
      @(posedge clk); #1;
      idle(2);

      // Reset in the middle of a frame
      send(8'h99);
      do_reset(1'b0);
      send(8'h5A);
      send(8'hA6);
      @(negedge clk);
      chk("t6_wdata", act_wdata, 32'h0000_005A);
      chk("t6_addr", {16'h0, act_addr}, 32'h0000_00A6);
      @(negedge clk);
      chk("t6_cnt", {16'h0, act_cnt}, 32'h1);
      @(posedge clk); #1;

      // frame_count (4 bits here) wraps 15 -> 0
      for (int i = 0; i < 15; i++) begin
         send(8'(i));
         send(8'(8'hF0 + i));
         idle(2);
      end
      @(negedge clk);
      chk("t7_cnt_wrap", {16'h0, act_cnt}, 32'h0);
      @(posedge clk); #1;

      // Address-first 2+2 configuration
      do_reset(1'b1);
      send(8'h12);
      send(8'h34);
      send(8'hBE);
      send(8'hEF);
      @(negedge clk);
      chk("t2_we", {31'h0, act_we}, 32'h1);
      chk("t2_addr", {16'h0, act_addr}, 32'h0000_1234);
      chk("t2_wdata", act_wdata, 32'h0000_BEEF);
      @(negedge clk);
      chk("t2_cnt", {16'h0, act_cnt}, 32'h1);
      @(posedge clk); #1;
      idle(2);

      chk("total_timeouts", to_count, 32'd1);
      chk("total_overruns", ov_count, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
